hazard_ctrl: RTL and testbench

- Pipeline hazard controller that sits beside the forwarding unit and sequences the IF/DE/EX/MEM stages.
- Detects hazards that forwarding cannot resolve: load-use, long-latency (div/mul) results pending in a scoreboard, write-after-write to pending registers, and fences.
- Generates stage stall, bubble and flush controls, including a multi-cycle redirect flush after a taken branch or mispredict.

---
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, long-latency scoreboard, fence and
// redirect-flush sequencing for the IF/DE/EX/MEM stages.
module hazard_ctrl #(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int NREGS            = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             de_valid,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic [4:0]       de_rd,
    input  logic             de_rs1_used,
    input  logic             de_rs2_used,
    input  logic             de_wen,
    input  logic             de_fence,
    input  logic             de_long,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic             ex_wen,
    input  logic [4:0]       ex_rd,
    input  logic             mem_valid,
    input  logic             mem_busy,
    input  logic             ex_redirect,
    input  logic             lu_busy,
    input  logic             lu_done,
    input  logic [4:0]       lu_rd,
    output logic             stall_if,
    output logic             stall_de,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             flush_if,
    output logic             flush_de,
    output logic [NREGS-1:0] sb_pending
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FENCE = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic [2:0]       cnt_r, cnt_next_s;
    logic [NREGS-1:0] sb_r, sb_next_s;
    logic             load_use_s, sb_haz_s, struct_s, drain_busy_s;
    logic             sb_set_s, sb_clr_s;

    // Hazard detection against the EX stage and the registered scoreboard only
    always_comb begin
        load_use_s   = ex_valid & ex_is_load & ex_wen & (ex_rd != 5'd0) & de_valid &
                       (((ex_rd == de_rs1) & de_rs1_used) | ((ex_rd == de_rs2) & de_rs2_used));
        sb_haz_s     = de_valid & ((sb_r[de_rs1] & de_rs1_used) |
                                   (sb_r[de_rs2] & de_rs2_used) |
                                   (sb_r[de_rd]  & de_wen));
        struct_s     = de_valid & de_long & lu_busy;
        drain_busy_s = (sb_r != {NREGS{1'b0}}) | ex_valid | mem_valid;
    end

    // Stage controls and FSM next state; priority mem_busy > redirect > fence > data hazard
    always_comb begin
        stall_if     = 1'b0;
        stall_de     = 1'b0;
        stall_ex     = 1'b0;
        bubble_ex    = 1'b0;
        flush_if     = 1'b0;
        flush_de     = 1'b0;
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        if (reset) begin
            state_next_s = ST_RUN;
            cnt_next_s   = 3'd0;
        end else if (mem_busy) begin
            stall_if = 1'b1;
            stall_de = 1'b1;
            stall_ex = 1'b1;
        end else if (ex_redirect) begin
            flush_if     = 1'b1;
            flush_de     = 1'b1;
            cnt_next_s   = 3'(REDIRECT_BUBBLES);
            state_next_s = (REDIRECT_BUBBLES != 0) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_r)
                ST_FLUSH: begin
                    flush_if   = 1'b1;
                    flush_de   = 1'b1;
                    cnt_next_s = cnt_r - 3'd1;
                    if (cnt_r <= 3'd1) begin
                        cnt_next_s   = 3'd0;
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_FLUSH;
                    end
                end
                ST_FENCE: begin
                    // The fence leaves DE in the same cycle the machine drains
                    if (!drain_busy_s) begin
                        state_next_s = ST_RUN;
                    end else begin
                        stall_if  = 1'b1;
                        stall_de  = 1'b1;
                        bubble_ex = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (de_valid & de_fence & drain_busy_s) begin
                        state_next_s = ST_FENCE;
                        stall_if     = 1'b1;
                        stall_de     = 1'b1;
                        bubble_ex    = 1'b1;
                    end else if (load_use_s | sb_haz_s | struct_s) begin
                        stall_if  = 1'b1;
                        stall_de  = 1'b1;
                        bubble_ex = 1'b1;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                default: begin
                    state_next_s = ST_RUN;
                    cnt_next_s   = 3'd0;
                end
            endcase
        end
    end

    // Scoreboard update: long op leaving DE sets its bit, long-unit writeback clears; set wins
    always_comb begin
        sb_set_s  = ~reset & ~mem_busy & ~stall_de & ~flush_de &
                    de_valid & de_long & de_wen & (de_rd != 5'd0);
        sb_clr_s  = ~reset & lu_done & (lu_rd != 5'd0);
        sb_next_s = sb_r;
        if (sb_clr_s) begin
            sb_next_s = sb_next_s & ~({{(NREGS-1){1'b0}}, 1'b1} << lu_rd);
        end else begin
            sb_next_s = sb_next_s;
        end
        if (sb_set_s) begin
            sb_next_s = sb_next_s | ({{(NREGS-1){1'b0}}, 1'b1} << de_rd);
        end else begin
            sb_next_s = sb_next_s;
        end
    end

    // State, redirect counter and scoreboard registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
            cnt_r   <= 3'd0;
            sb_r    <= {NREGS{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            sb_r    <= sb_next_s;
        end
    end

    assign sb_pending = sb_r;

    hazard_ctrl_chk u_chk (
        .clk     (clk),
        .reset   (reset),
        .sb_set  (sb_set_s),
        .sb_clr  (sb_clr_s),
        .set_idx (de_rd),
        .clr_idx (lu_rd)
    );

endmodule

// Checker: a scoreboard set and clear must never target the same register.
module hazard_ctrl_chk (
    input logic       clk,
    input logic       reset,
    input logic       sb_set,
    input logic       sb_clr,
    input logic [4:0] set_idx,
    input logic [4:0] clr_idx
);

    // WAW stalling should make a same-index set/clear collision unreachable
    set_clr_collide: assert property (@(posedge clk) disable iff (reset)
        !(sb_set && sb_clr && (set_idx == clr_idx)));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (REDIRECT_BUBBLES = 2).
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        de_valid, de_rs1_used, de_rs2_used, de_wen, de_fence, de_long;
    logic [4:0]  de_rs1, de_rs2, de_rd, ex_rd, lu_rd;
    logic        ex_valid, ex_is_load, ex_wen, mem_valid, mem_busy, ex_redirect;
    logic        lu_busy, lu_done;
    logic        stall_if, stall_de, stall_ex, bubble_ex, flush_if, flush_de;
    logic [31:0] sb_pending;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_HAZ   = 6'b110100;
    localparam logic [5:0] C_FRZ   = 6'b111000;
    localparam logic [5:0] C_FLUSH = 6'b000011;

    hazard_ctrl #(.REDIRECT_BUBBLES(2), .NREGS(32)) dut (
        .clk(clk), .reset(reset),
        .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rd(de_rd),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used), .de_wen(de_wen),
        .de_fence(de_fence), .de_long(de_long),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_wen(ex_wen), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_busy(mem_busy), .ex_redirect(ex_redirect),
        .lu_busy(lu_busy), .lu_done(lu_done), .lu_rd(lu_rd),
        .stall_if(stall_if), .stall_de(stall_de), .stall_ex(stall_ex),
        .bubble_ex(bubble_ex), .flush_if(flush_if), .flush_de(flush_de),
        .sb_pending(sb_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        de_valid = 1'b0; de_rs1 = 5'd0; de_rs2 = 5'd0; de_rd = 5'd0;
        de_rs1_used = 1'b0; de_rs2_used = 1'b0; de_wen = 1'b0;
        de_fence = 1'b0; de_long = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_wen = 1'b0; ex_rd = 5'd0;
        mem_valid = 1'b0; mem_busy = 1'b0; ex_redirect = 1'b0;
        lu_busy = 1'b0; lu_done = 1'b0; lu_rd = 5'd0;
    endtask

    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        #1;
        obs = {stall_if, stall_de, stall_ex, bubble_ex, flush_if, flush_de};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_sb(input string tag, input logic [31:0] exp);
        #1;
        n_assert++;
        assert (sb_pending === exp) else begin
            n_fail++;
            $error("FAIL %s sb observed=%h expected=%h", tag, sb_pending, exp);
        end
    endtask

    task automatic de_long_op(input logic [4:0] rd);
        idle();
        de_valid = 1'b1; de_long = 1'b1; de_wen = 1'b1; de_rd = rd;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        ex_redirect = 1'b1; mem_busy = 1'b1;
        chk_ctl("reset_outputs", C_NONE);
        chk_sb("reset_sb", 32'h0);
        tick(); tick();
        reset = 1'b0;
        idle();
        chk_ctl("idle", C_NONE);

        // Load-use on rs1, then EX holds the bubble
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd5;
        de_valid = 1'b1; de_rs1 = 5'd5; de_rs1_used = 1'b1;
        chk_ctl("load_use_rs1", C_HAZ);
        tick();
        ex_valid = 1'b0;
        chk_ctl("load_use_released", C_NONE);
        ex_valid = 1'b1; ex_rd = 5'd0; de_rs1 = 5'd0;
        chk_ctl("load_use_x0", C_NONE);
        ex_rd = 5'd9; de_rs1 = 5'd1; de_rs2 = 5'd9; de_rs2_used = 1'b1;
        chk_ctl("load_use_rs2", C_HAZ);
        de_rs2_used = 1'b0;
        chk_ctl("load_use_rs2_unused", C_NONE);
        tick();

        // Scoreboard: div x7 then dependent read, WAW, and delayed release
        de_long_op(5'd7);
        chk_ctl("div_issue", C_NONE);
        tick();
        idle();
        chk_sb("sb_set_7", 32'h0000_0080);
        de_valid = 1'b1; de_rs1 = 5'd7; de_rs1_used = 1'b1;
        chk_ctl("sb_raw_stall", C_HAZ);
        tick();
        de_long_op(5'd7);
        chk_ctl("sb_waw_stall", C_HAZ);
        tick();
        idle();
        de_valid = 1'b1; de_rs1 = 5'd7; de_rs1_used = 1'b1;
        lu_done = 1'b1; lu_rd = 5'd7;
        chk_ctl("sb_no_bypass", C_HAZ);
        tick();
        lu_done = 1'b0;
        chk_sb("sb_clear_7", 32'h0);
        chk_ctl("sb_released", C_NONE);
        tick();
        de_long_op(5'd2);
        lu_busy = 1'b1;
        chk_ctl("structural", C_HAZ);
        tick();
        de_long_op(5'd0);
        tick();
        idle();
        chk_sb("sb_x0_never_set", 32'h0);

        // Redirect: three flush cycles; DE hazards and long issue are ignored
        ex_redirect = 1'b1;
        chk_ctl("redir_c0", C_FLUSH);
        tick();
        idle();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd5;
        de_valid = 1'b1; de_rs1 = 5'd5; de_rs1_used = 1'b1;
        chk_ctl("redir_c1", C_FLUSH);
        tick();
        de_long_op(5'd6);
        chk_ctl("redir_c2", C_FLUSH);
        tick();
        idle();
        chk_ctl("redir_c3_done", C_NONE);
        chk_sb("redir_no_set", 32'h0);
        tick();

        // Second redirect in cycle 2 extends flush to cycle 4
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        tick();
        ex_redirect = 1'b1;
        chk_ctl("redir2_c2", C_FLUSH);
        tick();
        ex_redirect = 1'b0;
        chk_ctl("redir2_c3", C_FLUSH);
        tick();
        chk_ctl("redir2_c4", C_FLUSH);
        tick();
        chk_ctl("redir2_c5_done", C_NONE);
        tick();

        // mem_busy freeze with a held redirect; lu_done still clears
        de_long_op(5'd4);
        tick();
        idle();
        chk_sb("sb_set_4", 32'h0000_0010);
        mem_busy = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lu_done = (i == 1); lu_rd = 5'd4;
            chk_ctl("mem_busy_freeze", C_FRZ);
            tick();
        end
        lu_done = 1'b0;
        chk_sb("freeze_clear_4", 32'h0);
        mem_busy = 1'b0;
        chk_ctl("freeze_redirect", C_FLUSH);
        tick();
        ex_redirect = 1'b0;
        chk_ctl("freeze_flush_c1", C_FLUSH);
        tick();
        chk_ctl("freeze_flush_c2", C_FLUSH);
        tick();
        chk_ctl("freeze_flush_done", C_NONE);

        // Fence waits for sb[3] and an empty EX/MEM
        de_long_op(5'd3);
        tick();
        idle();
        chk_sb("sb_set_3", 32'h0000_0008);
        de_valid = 1'b1; de_fence = 1'b1; ex_valid = 1'b1;
        chk_ctl("fence_enter", C_HAZ);
        tick();
        chk_ctl("fence_hold_ex", C_HAZ);
        tick();
        ex_valid = 1'b0; lu_done = 1'b1; lu_rd = 5'd3;
        chk_ctl("fence_hold_lu_done", C_HAZ);
        tick();
        lu_done = 1'b0;
        chk_ctl("fence_exit", C_NONE);
        tick();
        idle();
        de_valid = 1'b1; de_fence = 1'b1;
        chk_ctl("fence_no_wait", C_NONE);
        tick();

        // Reset in the middle of a flush with sb = 0x90
        de_long_op(5'd4);
        tick();
        de_long_op(5'd7);
        tick();
        idle();
        chk_sb("sb_0x90", 32'h0000_0090);
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        chk_ctl("pre_reset_flush", C_FLUSH);
        reset = 1'b1;
        chk_ctl("mid_flush_reset", C_NONE);
        chk_sb("mid_flush_reset_sb", 32'h0);
        tick();
        reset = 1'b0;
        chk_ctl("after_reset_run", C_NONE);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
